tdm_demultiplexer: RTL and testbench
====================================

Name: tdm_demultiplexer

Overview:
- Receive end of the 4-to-1 multiplexer path. A transmitter drives the mux select through 0,1,2,3 and sends one sample per beat. This block takes that serial sample stream and distributes it back into four channel registers.
- Detects frame alignment from a sync marker and tracks the channel index with a 2-bit counter.
- Publishes a complete 4-channel word atomically once per frame, with lock and error status.

Parameters:
- WIDTH, 1, bits per channel sample (the mux path is 1 bit wide).
- TIMEOUT, 16, idle cycles in LOCKED before loss of lock (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  serial sample from the mux output.
- din_valid  input  1  din carries a sample this cycle.
- frame_sync  input  1  qualified by din_valid; marks the current sample as channel 0.
- dout  output  4*WIDTH  last complete frame; channel k at bits [k*WIDTH +: WIDTH], channel 0 at the LSBs.
- frame_valid  output  1  one-cycle pulse when dout updates.
- sel  output  2  channel index the next valid sample is written to.
- locked  output  1  high in state LOCKED.
- sync_err  output  1  one-cycle pulse on a misaligned sync.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - dout=0, frame_valid=0, sel=0, locked=0, sync_err=0.
  - Shadow registers cleared; state HUNT.
- Internal storage: four WIDTH-bit shadow registers sh0..sh3 and a 2-bit counter cnt. sel equals cnt.
- State HUNT:
  - din_valid=1 and frame_sync=0: sample discarded; no state change.
  - din_valid=1 and frame_sync=1: sh0<=din, cnt<=1, go to LOCKED. locked rises the next cycle.
- State LOCKED, din_valid=1 and frame_sync=0:
  - sh[cnt]<=din, cnt<=cnt+1 (wraps 3->0).
  - When cnt==3: next cycle dout={din,sh2,sh1,sh0} and frame_valid=1 for exactly one cycle, so latency is 1 cycle after the channel-3 sample.
- State LOCKED, din_valid=1 and frame_sync=1:
  - cnt==0: aligned. sh0<=din, cnt<=1, no error.
  - cnt!=0: misaligned. sync_err=1 the next cycle for one cycle. The partial frame is discarded (no frame_valid, dout unchanged), sh0<=din, cnt<=1. Remain LOCKED.
- din_valid=0: no register changes except the optional timeout counter. Gaps between samples are legal at any channel position.
- dout holds its value between frames. It only ever changes as a complete frame; a partial frame is never visible.
- Simultaneous channel-3 sample and frame_sync (cnt==3, frame_sync=1): this is a misalignment. sync_err pulses, frame_valid stays 0, and the sample is stored as channel 0.
- Reset mid-frame: all state cleared immediately. After rst_n rises, the block needs a new frame_sync in HUNT.
- frame_valid and sync_err are registered. They never assert in the same cycle.

Optional Feature:
- Macro: TDM_DEMUX_TIMEOUT_EN.
- Defined:
  - An idle counter of width clog2(TIMEOUT+1) increments each LOCKED cycle with din_valid=0, and clears on any valid sample.
  - When it reaches TIMEOUT: state<=HUNT, cnt<=0, partial frame discarded, dout retained, locked falls the next cycle. No sync_err is raised.
- Not defined: no idle counter; LOCKED is left only by reset.

Test Plan:
- Reset then lock: rst_n low 3 cycles, check all outputs 0. Send samples 1,0,0,1 (WIDTH=1) with sync on the first -> locked=1 after the sync beat; frame_valid pulses once 1 cycle after the 4th sample with dout=4'b1001; sel sequence 0,1,2,3,0.
- Back-to-back frames with gaps: frames 0,0,1,0 then 1,1,0,1, with din_valid=0 holes between samples -> dout=4'b0100 then 4'b1011, exactly two frame_valid pulses, dout stable between them.
- Hunt discard: 3 valid samples without sync after reset -> locked stays 0, no frame_valid. Then a normal synced frame 1,1,1,1 -> dout=4'b1111.
- Misaligned sync: in LOCKED send ch0=1, ch1=1, then sync with din=0, then 1,1,0 -> sync_err pulses once; no frame_valid for the broken frame; next frame_valid gives dout=4'b0110.
- Reset mid-frame: after 2 samples assert rst_n -> outputs 0 immediately, sel=0, locked=0. Unsynced samples afterwards are ignored.
- Timeout (TDM_DEMUX_TIMEOUT_EN, TIMEOUT=16): lock and send 2 samples, then 16 idle cycles -> locked=0, previous dout retained, sync_err=0. Check that 15 idle cycles keep lock.

Source files
------------

// File: rtl/tdm_demultiplexer.sv
// TDM receive side: rebuilds 4-channel frames from the serial mux stream, aligned by frame_sync.
// Optional loss-of-lock timeout: define TDM_DEMUX_TIMEOUT_EN.
module tdm_demultiplexer #(
    parameter int unsigned WIDTH = 1
`ifdef TDM_DEMUX_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 16
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   din,
    input  logic               din_valid,
    input  logic               frame_sync,
    output logic [4*WIDTH-1:0] dout,
    output logic               frame_valid,
    output logic [1:0]         sel,
    output logic               locked,
    output logic               sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       cnt;
    logic [WIDTH-1:0] sh0;
    logic [WIDTH-1:0] sh1;
    logic [WIDTH-1:0] sh2;
    logic [WIDTH-1:0] sh3;

`ifdef TDM_DEMUX_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle;
`endif

    assign sel = cnt;

    // Channel 3 arrives live with the publish; sh3 mirrors it so the shadow set stays complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            cnt         <= 2'd0;
            sh0         <= '0;
            sh1         <= '0;
            sh2         <= '0;
            sh3         <= '0;
            dout        <= '0;
            frame_valid <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
`ifdef TDM_DEMUX_TIMEOUT_EN
            idle        <= '0;
`endif
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            case (state)
                HUNT: begin
                    if (din_valid && frame_sync) begin
                        sh0    <= din;
                        cnt    <= 2'd1;
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (din_valid) begin
`ifdef TDM_DEMUX_TIMEOUT_EN
                        idle <= '0;
`endif
                        if (frame_sync) begin
                            // Sync anywhere but channel 0 drops the partial frame and restarts.
                            if (cnt != 2'd0) begin
                                sync_err <= 1'b1;
                            end
                            sh0 <= din;
                            cnt <= 2'd1;
                        end else begin
                            case (cnt)
                                2'd0: sh0 <= din;
                                2'd1: sh1 <= din;
                                2'd2: sh2 <= din;
                                default: begin
                                    sh3         <= din;
                                    dout        <= {din, sh2, sh1, sh0};
                                    frame_valid <= 1'b1;
                                end
                            endcase
                            cnt <= cnt + 2'd1;
                        end
                    end
`ifdef TDM_DEMUX_TIMEOUT_EN
                    else if (idle == IDLE_W'(TIMEOUT - 1)) begin
                        // Counter reaches TIMEOUT on this edge: silently drop back to HUNT.
                        state  <= HUNT;
                        locked <= 1'b0;
                        cnt    <= 2'd0;
                        idle   <= '0;
                    end else begin
                        idle <= idle + IDLE_W'(1);
                    end
`endif
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Directed self-checking bench for tdm_demultiplexer (WIDTH=1).
`timescale 1ns/1ps
module tb_tdm_demultiplexer;

    logic       clk;
    logic       rst_n;
    logic [0:0] din;
    logic       din_valid;
    logic       frame_sync;
    logic [3:0] dout;
    logic       frame_valid;
    logic [1:0] sel;
    logic       locked;
    logic       sync_err;

    int passed;
    int total;
    int fv_cnt;
    int se_cnt;
    int fv_snap;
    int se_snap;

    tdm_demultiplexer #(.WIDTH(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .dout        (dout),
        .frame_valid (frame_valid),
        .sel         (sel),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_cnt <= fv_cnt + 1;
        if (sync_err === 1'b1)    se_cnt <= se_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock beat with the given inputs; returns 1ns after the edge.
    task automatic step(input logic v, input logic s, input logic d);
        din_valid  = v;
        frame_sync = s;
        din        = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        din_valid = 1'b0; frame_sync = 1'b0; din = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        passed = 0; total = 0; fv_cnt = 0; se_cnt = 0;
        rst_n = 1'b0; din_valid = 1'b0; frame_sync = 1'b0; din = 1'b0;

        // Reset state
        do_reset();
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_fv", 32'(frame_valid), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_serr", 32'(sync_err), 32'h0);

        // Lock and first frame 1,0,0,1
        step(1, 1, 1);
        chk("lock_locked", 32'(locked), 32'h1);
        chk("lock_sel1", 32'(sel), 32'h1);
        step(1, 0, 0);
        chk("lock_sel2", 32'(sel), 32'h2);
        step(1, 0, 0);
        chk("lock_sel3", 32'(sel), 32'h3);
        chk("lock_fv_early", 32'(frame_valid), 32'h0);
        step(1, 0, 1);
        chk("f1_fv", 32'(frame_valid), 32'h1);
        chk("f1_dout", 32'(dout), 32'h9);
        chk("f1_sel0", 32'(sel), 32'h0);
        step(0, 0, 0);
        chk("f1_fv_drop", 32'(frame_valid), 32'h0);
        chk("f1_dout_hold", 32'(dout), 32'h9);

        // Back-to-back frames with gaps: 0,0,1,0 then 1,1,0,1
        fv_snap = fv_cnt;
        step(1, 1, 0); step(0, 0, 0);
        step(1, 0, 0); step(0, 0, 0);
        step(1, 0, 1); step(0, 0, 0);
        chk("gap_sel_hold", 32'(sel), 32'h3);
        step(1, 0, 0);
        chk("fa_fv", 32'(frame_valid), 32'h1);
        chk("fa_dout", 32'(dout), 32'h4);
        step(0, 0, 0);
        step(1, 1, 1);
        chk("fb_aligned_serr", 32'(sync_err), 32'h0);
        step(0, 0, 0);
        step(1, 0, 1); step(0, 0, 0);
        chk("fb_dout_stable", 32'(dout), 32'h4);
        step(1, 0, 0); step(0, 0, 0);
        step(1, 0, 1);
        chk("fb_fv", 32'(frame_valid), 32'h1);
        chk("fb_dout", 32'(dout), 32'hB);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("gap_fv_pulses", 32'(fv_cnt - fv_snap), 32'd2);

        // Hunt discard then synced frame 1,1,1,1
        do_reset();
        fv_snap = fv_cnt;
        step(1, 0, 1); step(1, 0, 0); step(1, 0, 1);
        chk("hunt_locked", 32'(locked), 32'h0);
        chk("hunt_sel", 32'(sel), 32'h0);
        step(1, 1, 1); step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
        chk("hunt_dout", 32'(dout), 32'hF);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("hunt_fv_pulses", 32'(fv_cnt - fv_snap), 32'd1);

        // Misaligned sync at cnt==2
        se_snap = se_cnt;
        fv_snap = fv_cnt;
        step(1, 1, 1); step(1, 0, 1);
        step(1, 1, 0);
        chk("mis_serr", 32'(sync_err), 32'h1);
        chk("mis_fv", 32'(frame_valid), 32'h0);
        chk("mis_sel", 32'(sel), 32'h1);
        chk("mis_dout_kept", 32'(dout), 32'hF);
        step(1, 0, 1);
        chk("mis_serr_drop", 32'(sync_err), 32'h0);
        step(1, 0, 1);
        step(1, 0, 0);
        chk("mis_fv_next", 32'(frame_valid), 32'h1);
        chk("mis_dout_next", 32'(dout), 32'h6);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("mis_serr_pulses", 32'(se_cnt - se_snap), 32'd1);
        chk("mis_fv_pulses", 32'(fv_cnt - fv_snap), 32'd1);

        // Sync coinciding with channel-3 slot
        step(1, 1, 1); step(1, 0, 1); step(1, 0, 1);
        step(1, 1, 0);
        chk("c3_serr", 32'(sync_err), 32'h1);
        chk("c3_fv", 32'(frame_valid), 32'h0);
        chk("c3_dout_kept", 32'(dout), 32'h6);
        chk("c3_sel", 32'(sel), 32'h1);
        step(1, 0, 0); step(1, 0, 1); step(1, 0, 1);
        chk("c3_fv_next", 32'(frame_valid), 32'h1);
        chk("c3_dout_next", 32'(dout), 32'hC);
        step(0, 0, 0);

        // Reset mid-frame
        step(1, 1, 1); step(1, 0, 1);
        chk("mid_sel_pre", 32'(sel), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("mid_dout", 32'(dout), 32'h0);
        chk("mid_sel", 32'(sel), 32'h0);
        chk("mid_locked", 32'(locked), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fv_snap = fv_cnt;
        step(1, 0, 1); step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("mid_ign_locked", 32'(locked), 32'h0);
        chk("mid_ign_sel", 32'(sel), 32'h0);
        chk("mid_ign_fv", 32'(fv_cnt - fv_snap), 32'd0);

        // Idle behaviour in LOCKED: frame 1,0,1,0 then a partial frame, then gaps
        step(1, 1, 1); step(1, 0, 0); step(1, 0, 1); step(1, 0, 0);
        chk("idle_pre_dout", 32'(dout), 32'h5);
        step(1, 1, 1); step(1, 0, 1);
`ifdef TDM_DEMUX_TIMEOUT_EN
        repeat (15) step(0, 0, 0);
        chk("to15_locked", 32'(locked), 32'h1);
        chk("to15_sel", 32'(sel), 32'h2);
        step(0, 0, 0);
        chk("to16_locked", 32'(locked), 32'h0);
        chk("to16_dout", 32'(dout), 32'h5);
        chk("to16_serr", 32'(sync_err), 32'h0);
        chk("to16_sel", 32'(sel), 32'h0);
        step(1, 0, 1);
        chk("to_hunt_locked", 32'(locked), 32'h0);
        step(1, 1, 0); step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
        chk("to_relock_dout", 32'(dout), 32'hE);
`else
        repeat (20) step(0, 0, 0);
        chk("idle_locked", 32'(locked), 32'h1);
        chk("idle_sel", 32'(sel), 32'h2);
        chk("idle_dout", 32'(dout), 32'h5);
        step(1, 0, 1); step(1, 0, 0);
        chk("idle_fv", 32'(frame_valid), 32'h1);
        chk("idle_dout_new", 32'(dout), 32'h7);
`endif
        step(0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
